serial_frame_receiver: RTL and testbench

- Receive end of the trigger-started serial link that carries 16-bit filtered ADC words, one bit per clock, with a valid strobe on the first bit only.
- Rebuild each word and check the framing.
- Buffer rebuilt words in a small FIFO with a ready/valid output.
- Keep error and overflow status.
- Used on-chip for loopback self-test of the ADC serial outputs, and as the reference decoder in the companion capture FPGA.

---
 rtl/serial_frame_receiver_if.sv | 27 ++
 rtl/serial_frame_receiver.sv | 137 +++++++++++++
 tb/tb_serial_frame_receiver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_if.sv
// Serial link input plus ready/valid word output of the serial frame receiver.
// The slave modport is the receiver; the master modport is whoever drives the link and consumes words.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 16
);
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output ser_in,
    output ser_valid,
    output m_ready,
    input  m_data,
    input  m_valid
  );

  modport slave (
    input  ser_in,
    input  ser_valid,
    input  m_ready,
    output m_data,
    output m_valid
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Rebuilds MSB-first serial frames into words, checks framing, and buffers words
// in a show-ahead FIFO with sticky overflow and a saturating framing-error count.
module serial_frame_receiver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_frame_receiver_if.slave  bus,
  input  logic                    clr_status,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    overflow,
  output logic [7:0]              err_count
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               word_done, err, push, pop, full;
  logic [WIDTH-1:0]   word;

  // Only WIDTH-1 bits are stored; the final bit is appended straight from ser_in.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    err       = 1'b0;
    word      = {shreg_q, bus.ser_in};
    case (state_q)
      IDLE: begin
        if (bus.ser_valid) begin
          shreg_d    = '0;
          shreg_d[0] = bus.ser_in;
          cnt_d      = CW'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_valid) begin
          err        = 1'b1;
          shreg_d    = '0;
          shreg_d[0] = bus.ser_in;
          cnt_d      = CW'(1);
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          word_done = 1'b1;
          shreg_d   = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          shreg_d = word[WIDTH-2:0];
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // m_data is a registered copy of the head so it can hold its value once the FIFO drains.
  always_comb begin
    full      = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    pop       = m_valid_q && bus.m_ready;
    push      = word_done && (!full || pop);
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    m_valid_d = (rd_ptr_d != wr_ptr_d);
    m_data_d  = m_data_q;
    if (m_valid_d) begin
      if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) m_data_d = word;
      else                                               m_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_comb begin
    frame_err_d = err;
    overflow_d  = overflow_q | (word_done && full && !pop);
    err_cnt_d   = err_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      err_cnt_d  = err ? 8'd1 : 8'd0;
    end else if (err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign busy        = (state_q == SHIFT);
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver; delivered words are checked against a queue of expected words.
module tb_serial_frame_receiver;

  logic       clk;
  logic       rst_n;
  logic       clr_status;
  logic       busy;
  logic       frame_err;
  logic       overflow;
  logic [7:0] err_count;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_q[$];

  serial_frame_receiver_if #(.WIDTH(16)) bus();

  serial_frame_receiver #(.WIDTH(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_status (clr_status),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake seen before the next rising edge pops one expected word.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $error("FAIL unexpected_word observed=%0h expected=none", bus.m_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pop_data", 32'(bus.m_data), 32'(e));
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input bit exp_err, input bit rdy_last);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      if (i != 15) begin
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("frame_err_in_frame", 32'(frame_err), (i == 14) ? 32'(exp_err) : 32'd0);
      end
      bus.ser_valid = (i == 15);
      bus.ser_in    = w[i];
      if (rdy_last && i == 0) bus.m_ready = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ser_valid = (i == 0);
      bus.ser_in    = w[15-i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_status    = 1'b0;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    // Single frame, consumer always ready
    bus.m_ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0, 1'b0);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    chk("t1_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_m_data", 32'(bus.m_data), 32'hA5C3);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    chk("t1_m_valid_one_cycle", 32'(bus.m_valid), 32'd0);

    // Back-to-back frames buffered, then drained on consecutive cycles
    bus.m_ready = 1'b0;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h8000);
    send_word(16'h0001, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    send_word(16'h8000, 1'b0, 1'b0);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    chk("t2_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t2_head", 32'(bus.m_data), 32'h0001);
    @(negedge clk);
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_empty", 32'(bus.m_valid), 32'd0);
    chk("t2_q_drained", 32'(exp_q.size()), 32'd0);

    // Framing error: new frame starts at bit 7 of an unfinished one
    send_bits(16'hBEEF, 8);
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 1'b1, 1'b0);
    idle(2);
    chk("t3_err_count", 32'(err_count), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd0);
    chk("t3_q_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: fifth word dropped while consumer stalls
    bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(16'h0010 + 16'(k));
      send_word(16'h0010 + 16'(k), 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.ser_valid = 1'b0;
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_head", 32'(bus.m_data), 32'h0010);
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_empty", 32'(bus.m_valid), 32'd0);
    chk("t4_q_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status  = 1'b0;
    bus.m_ready = 1'b0;
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    chk("t4_err_count_cleared", 32'(err_count), 32'd0);

    // Full FIFO with a pop on the completion edge of the fifth word
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(16'h0020 + 16'(k));
      send_word(16'h0020 + 16'(k), 1'b0, k == 4);
    end
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.m_ready   = 1'b0;
    chk("t5_no_overflow", 32'(overflow), 32'd0);
    chk("t5_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t5_head", 32'(bus.m_data), 32'h0021);
    @(negedge clk);
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_empty", 32'(bus.m_valid), 32'd0);
    chk("t5_q_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-frame with words buffered
    bus.m_ready = 1'b0;
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0031);
    send_word(16'h0030, 1'b0, 1'b0);
    send_word(16'h0031, 1'b0, 1'b0);
    send_bits(16'h1357, 7);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    exp_q.push_back(16'h5A5A);
    send_word(16'h5A5A, 1'b0, 1'b0);
    idle(2);
    chk("t6_q_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_m_valid_after", 32'(bus.m_valid), 32'd0);

    // Error counter saturation: ser_valid held high gives one error per cycle after the first
    for (int k = 0; k <= 260; k++) begin
      @(negedge clk);
      if (k == 101) chk("t7_err_count_100", 32'(err_count), 32'd100);
      if (k == 50) chk("t7_frame_err_high", 32'(frame_err), 32'd1);
      bus.ser_valid = 1'b1;
      bus.ser_in    = 1'b0;
    end
    @(negedge clk);
    chk("t7_err_count_sat", 32'(err_count), 32'd255);
    clr_status = 1'b1;
    @(negedge clk);
    chk("t7_clr_with_err", 32'(err_count), 32'd1);
    chk("t7_frame_err_clr", 32'(frame_err), 32'd1);
    clr_status    = 1'b0;
    bus.ser_valid = 1'b0;
    exp_q.push_back(16'h0000);
    idle(18);
    chk("t7_q_drained", 32'(exp_q.size()), 32'd0);
    chk("t7_busy_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
